// File: rtl/reg_file_pkg.sv
//------------------------------------------------------------------------------
// reg_file_pkg
//   Shared types and helpers for the 2-read / 1-write register file.
//   - clr_state_t : clear sequencer states (IDLE, CLEAR)
//   - byte_merge  : byte-lane merge of an old and a new word under a byte
//                   enable mask. The array write path and both read-port
//                   bypass paths call it, so their merge behaviour cannot
//                   drift apart.
//------------------------------------------------------------------------------
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // byte_merge works at a fixed maximum width. Callers zero-extend their
    // operands and size-cast the result back to their own DATA_W. Unused upper
    // lanes are constant and fold away.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_BE_W   = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BE_W-1:0]   be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
//------------------------------------------------------------------------------
// reg_file_rd_port
//   One registered read port of the register file.
//   rd_data is loaded every cycle from the entry at rd_addr, with these
//   overrides, listed from highest priority:
//     - out-of-range address, or entry 0 when ZERO_REG=1 -> 0
//     - entry being cleared this cycle                    -> 0 (clear bypass)
//     - entry being written this cycle                    -> merged word (write-first)
//   Ports:
//     clk, reset_n     : clock, async active-low reset
//     rd_addr          : read address, sampled at the rising edge
//     entries          : current array contents
//     wr_accept/wr_*   : the write that is being committed this cycle
//     clr_active/cnt   : clear sequencer activity and the entry it zeroes now
//     rd_data          : registered read data
//------------------------------------------------------------------------------
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   entries [DEPTH],
    input  logic                wr_accept,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr_active,
    input  logic [ADDR_W-1:0]   clr_cnt,
    output logic [DATA_W-1:0]   rd_data
);

    logic [DATA_W-1:0] rd_next;

    // Comparing against each legal index, rather than indexing the array
    // directly, makes out-of-range addresses (DEPTH not a power of two)
    // fall through to the zero default.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                if (clr_active && clr_cnt == ADDR_W'(i)) begin
                    rd_next = '0;
                end else if (wr_accept && wr_addr == ADDR_W'(i)) begin
                    rd_next = DATA_W'(byte_merge(MAX_DATA_W'(entries[i]),
                                                 MAX_DATA_W'(wr_data),
                                                 MAX_BE_W'(wr_be)));
                end else begin
                    rd_next = entries[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
//------------------------------------------------------------------------------
// reg_file_2r1w
//   Parametrised register file: one byte-maskable write port, two registered
//   read ports with write-first bypass, and a clear sequencer that zeroes one
//   entry per cycle.
//   Ports:
//     clk, reset_n        : clock, async active-low reset
//     wr_en/addr/be/data  : write request (byte enables per 8-bit lane)
//     rd_addr0/rd_addr1   : read addresses
//     rd_data0/rd_data1   : registered read data (1-cycle latency)
//     clr_req             : start a clear sequence (pulse or level)
//     clr_busy            : clear sequence in progress
//     wr_drop             : one-cycle pulse, a write was discarded during clear
//     dbg_state           : current clear sequencer state
//   Handshake: there is no back-pressure. A write is taken in the cycle that
//   wr_en is high, unless a clear is running; in that case it is discarded
//   and wr_drop reports it one cycle later. clr_req is sampled only in IDLE.
//------------------------------------------------------------------------------
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 8,
    parameter  int ZERO_REG = 0,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop,
    output clr_state_t        dbg_state
);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_addr_ok;
    logic              wr_accept;
    logic              clr_active;
    logic              wr_drop_q;

    assign clr_active = (state_q == CLEAR);
    assign clr_busy   = clr_active;
    assign dbg_state  = state_q;
    assign wr_drop    = wr_drop_q;

    // Write decode: address in range and not the hard-wired zero entry.
    always_comb begin
        wr_addr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                wr_addr_ok = 1'b1;
            end
        end
    end

    assign wr_accept = wr_en && !clr_active && wr_addr_ok;

    // Clear sequencer: state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer: next state. clr_req is ignored while clearing, so a
    // held request re-arms only after one IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Every write request that arrives during a clear is reported once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_en && clr_active;
        end
    end

    // Storage array: one DATA_W register per entry. The clear and write
    // conditions never hold together, because writes are refused while clearing.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [DATA_W-1:0] q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (clr_active && cnt_q == ADDR_W'(g)) begin
                q <= '0;
            end else if (wr_accept && wr_addr == ADDR_W'(g)) begin
                q <= DATA_W'(byte_merge(MAX_DATA_W'(q),
                                        MAX_DATA_W'(wr_data),
                                        MAX_BE_W'(wr_be)));
            end
        end

        assign mem_q[g] = q;
    end

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_rd_port0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr0),
        .entries    (mem_q),
        .wr_accept  (wr_accept),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .clr_active (clr_active),
        .clr_cnt    (cnt_q),
        .rd_data    (rd_data0)
    );

    reg_file_rd_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) u_rd_port1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr1),
        .entries    (mem_q),
        .wr_accept  (wr_accept),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data),
        .clr_active (clr_active),
        .clr_cnt    (cnt_q),
        .rd_data    (rd_data1)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
//------------------------------------------------------------------------------
// tb_reg_file_2r1w
//   Bench for reg_file_2r1w. Instance 0 uses the defaults (DEPTH=8,
//   ZERO_REG=0). Instance 1 uses DEPTH=6, ZERO_REG=1.
//------------------------------------------------------------------------------
module tb_reg_file_2r1w;
    import reg_file_pkg::*;

    localparam int DW = 32;
    localparam int AW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index = instance) ----------------
    logic          wr_en    [2];
    logic [AW-1:0] wr_addr  [2];
    logic [3:0]    wr_be    [2];
    logic [DW-1:0] wr_data  [2];
    logic [AW-1:0] rd_addr0 [2];
    logic [AW-1:0] rd_addr1 [2];
    logic          clr_req  [2];
    logic [DW-1:0] rd_data0 [2];
    logic [DW-1:0] rd_data1 [2];
    logic          clr_busy [2];
    logic          wr_drop  [2];
    clr_state_t    dbg_state[2];

    reg_file_2r1w #(.DATA_W(32), .DEPTH(8), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_be(wr_be[0]), .wr_data(wr_data[0]),
        .rd_addr0(rd_addr0[0]), .rd_addr1(rd_addr1[0]),
        .rd_data0(rd_data0[0]), .rd_data1(rd_data1[0]),
        .clr_req(clr_req[0]), .clr_busy(clr_busy[0]), .wr_drop(wr_drop[0]),
        .dbg_state(dbg_state[0])
    );

    reg_file_2r1w #(.DATA_W(32), .DEPTH(6), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_be(wr_be[1]), .wr_data(wr_data[1]),
        .rd_addr0(rd_addr0[1]), .rd_addr1(rd_addr1[1]),
        .rd_data0(rd_data0[1]), .rd_data1(rd_data1[1]),
        .clr_req(clr_req[1]), .clr_busy(clr_busy[1]), .wr_drop(wr_drop[1]),
        .dbg_state(dbg_state[1])
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_mem [2][8];
    bit            m_busy[2];
    int            m_cnt [2];
    bit            exp_busy[2];
    bit            exp_drop[2];

    function automatic int dep(int d);
        return (d == 0) ? 8 : 6;
    endfunction

    function automatic bit zr(int d);
        return d == 1;
    endfunction

    // Byte merge built from a 32-bit lane mask.
    function automatic logic [DW-1:0] merge(logic [DW-1:0] old_w, logic [DW-1:0] new_w,
                                            logic [3:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mask = mask | (32'hFF << (8 * b));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Value a read of address a returns this cycle.
    function automatic logic [DW-1:0] peek(int d, int a, bit acc, int wa, logic [DW-1:0] wword);
        if (a >= dep(d) || (zr(d) && a == 0)) return '0;
        if (m_busy[d] && m_cnt[d] == a)       return '0;
        if (acc && wa == a)                   return wword;
        return m_mem[d][a];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) m_mem[d][i] = '0;
            m_busy[d]   = 1'b0;
            m_cnt[d]    = 0;
            exp_busy[d] = 1'b0;
            exp_drop[d] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int            wa;
            bit            acc;
            logic [DW-1:0] wword;
            wa    = int'(wr_addr[d]);
            acc   = wr_en[d] && !m_busy[d] && wa < dep(d) && !(zr(d) && wa == 0);
            wword = merge(m_mem[d][wa], wr_data[d], wr_be[d]);
            exp_q.push_back(peek(d, int'(rd_addr0[d]), acc, wa, wword));
            exp_q.push_back(peek(d, int'(rd_addr1[d]), acc, wa, wword));
            exp_drop[d] = wr_en[d] && m_busy[d];
            if (m_busy[d]) begin
                m_mem[d][m_cnt[d]] = '0;
                if (m_cnt[d] == dep(d) - 1) m_busy[d] = 1'b0;
                else                        m_cnt[d]  = m_cnt[d] + 1;
            end else begin
                if (acc) m_mem[d][wa] = wword;
                if (clr_req[d]) begin
                    m_busy[d] = 1'b1;
                    m_cnt[d]  = 0;
                end
            end
            exp_busy[d] = m_busy[d];
        end
    endtask

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: predict, clock, compare every output of both instances.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rd_data0[%0d]", d), rd_data0[d], exp_q.pop_front());
            check($sformatf("rd_data1[%0d]", d), rd_data1[d], exp_q.pop_front());
            check($sformatf("clr_busy[%0d]", d), {31'b0, clr_busy[d]}, {31'b0, exp_busy[d]});
            check($sformatf("wr_drop[%0d]", d),  {31'b0, wr_drop[d]},  {31'b0, exp_drop[d]});
            check($sformatf("dbg_state[%0d]", d), {31'b0, dbg_state[d] == CLEAR},
                  {31'b0, exp_busy[d]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1'b0; wr_addr[d] = '0; wr_be[d] = '0; wr_data[d] = '0;
            rd_addr0[d] = '0; rd_addr1[d] = '0; clr_req[d] = 1'b0;
        end
    endtask

    task automatic drive_wr(int d, logic en, logic [AW-1:0] a, logic [3:0] be, logic [DW-1:0] data);
        wr_en[d] = en; wr_addr[d] = a; wr_be[d] = be; wr_data[d] = data;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic          en;
        logic [AW-1:0] wa;
        logic [3:0]    be;
        logic [DW-1:0] data;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t vecs[10];

    // Watchdog: every loop below is bounded, this only guards against a stall.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, drop_cnt, hits, k;

        vecs[0] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd0, 3'd1, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd2, 3'd3, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd4, 3'd5, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd6, 3'd7, 32'h0,        32'h0};
        vecs[4] = '{1'b1, 3'd3, 4'hF, 32'hDEADBEEF, 3'd0, 3'd1, 32'h0,        32'h0};
        vecs[5] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd3, 3'd3, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 3'd5, 4'hF, 32'h11223344, 3'd0, 3'd3, 32'h0,        32'hDEADBEEF};
        vecs[7] = '{1'b1, 3'd5, 4'h5, 32'hAABBCCDD, 3'd5, 3'd3, 32'h11BB33DD, 32'hDEADBEEF};
        vecs[8] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd0, 3'd5, 32'h0,        32'h11BB33DD};
        vecs[9] = '{1'b1, 3'd5, 4'h0, 32'hFFFFFFFF, 3'd5, 3'd5, 32'h11BB33DD, 32'h11BB33DD};

        // ---- reset ----
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset rd_data0", rd_data0[d], 32'h0);
            check("reset rd_data1", rd_data1[d], 32'h0);
            check("reset clr_busy", {31'b0, clr_busy[d]}, 32'h0);
            check("reset wr_drop",  {31'b0, wr_drop[d]},  32'h0);
        end
        reset_n = 1'b1;

        // ---- table-driven vectors on instance 0 ----
        for (int i = 0; i < 10; i++) begin
            drive_wr(0, vecs[i].en, vecs[i].wa, vecs[i].be, vecs[i].data);
            rd_addr0[0] = vecs[i].ra0;
            rd_addr1[0] = vecs[i].ra1;
            cycle();
            check($sformatf("vec%0d rd_data0", i), rd_data0[0], vecs[i].e0);
            check($sformatf("vec%0d rd_data1", i), rd_data1[0], vecs[i].e1);
        end
        idle_inputs();

        // ---- full clear with a dropped write in clear cycle 3 ----
        for (int i = 0; i < 8; i++) begin
            drive_wr(0, 1'b1, AW'(i), 4'hF, 32'hFFFFFFFF);
            cycle();
        end
        idle_inputs();
        clr_req[0] = 1'b1;
        cycle();
        clr_req[0] = 1'b0;
        busy_cnt = 0; drop_cnt = 0; k = 0;
        while (clr_busy[0] && k < 20) begin
            k++;
            busy_cnt++;
            if (k == 3) drive_wr(0, 1'b1, 3'd2, 4'hF, 32'h0BADF00D);
            else        drive_wr(0, 1'b0, 3'd0, 4'h0, 32'h0);
            rd_addr0[0] = AW'(k % 8);
            cycle();
            drop_cnt += int'(wr_drop[0]);
        end
        check("clear busy cycles", busy_cnt, 8);
        check("clear drop pulses", drop_cnt, 1);
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            rd_addr0[0] = AW'(i);
            rd_addr1[0] = AW'(7 - i);
            cycle();
            check($sformatf("after clear rd0 a%0d", i), rd_data0[0], 32'h0);
            check($sformatf("after clear rd1 a%0d", 7 - i), rd_data1[0], 32'h0);
        end

        // ---- instance 1: zero register and out-of-range writes ----
        idle_inputs();
        drive_wr(1, 1'b1, 3'd0, 4'hF, 32'h5);
        rd_addr0[1] = 3'd0;
        cycle();
        check("zr bypass a0", rd_data0[1], 32'h0);
        check("zr drop a0", {31'b0, wr_drop[1]}, 32'h0);
        drive_wr(1, 1'b1, 3'd7, 4'hF, 32'h5);
        rd_addr0[1] = 3'd7;
        cycle();
        check("zr bypass a7", rd_data0[1], 32'h0);
        check("zr drop a7", {31'b0, wr_drop[1]}, 32'h0);
        drive_wr(1, 1'b1, 3'd5, 4'hF, 32'h5);
        cycle();
        idle_inputs();
        rd_addr0[1] = 3'd0; rd_addr1[1] = 3'd7;
        cycle();
        check("zr read a0", rd_data0[1], 32'h0);
        check("zr read a7", rd_data1[1], 32'h0);
        rd_addr0[1] = 3'd5; rd_addr1[1] = 3'd6;
        cycle();
        check("zr read a5", rd_data0[1], 32'h5);
        check("zr read a6", rd_data1[1], 32'h0);

        // ---- reset asserted in clear cycle 4 ----
        idle_inputs();
        for (int i = 5; i < 8; i++) begin
            drive_wr(0, 1'b1, AW'(i), 4'hF, 32'h55500000 + i);
            cycle();
        end
        idle_inputs();
        clr_req[0] = 1'b1;
        cycle();
        clr_req[0] = 1'b0;
        repeat (3) cycle();
        check("pre-abort busy", {31'b0, clr_busy[0]}, 32'h1);
        reset_n = 1'b0;
        #2;
        model_reset();
        check("abort clr_busy", {31'b0, clr_busy[0]}, 32'h0);
        check("abort rd_data0", rd_data0[0], 32'h0);
        check("abort rd_data1", rd_data1[0], 32'h0);
        #2;
        reset_n = 1'b1;
        drive_wr(0, 1'b1, 3'd6, 4'hF, 32'hCAFE0006);
        cycle();
        idle_inputs();
        rd_addr0[0] = 3'd6; rd_addr1[0] = 3'd5;
        cycle();
        check("post-abort write a6", rd_data0[0], 32'hCAFE0006);
        check("post-abort a5 zero", rd_data1[0], 32'h0);
        rd_addr0[0] = 3'd7; rd_addr1[0] = 3'd3;
        cycle();
        check("post-abort a7 zero", rd_data0[0], 32'h0);
        check("post-abort a3 zero", rd_data1[0], 32'h0);

        // ---- simultaneous clr_req and write in IDLE ----
        idle_inputs();
        drive_wr(0, 1'b1, 3'd7, 4'hF, 32'h00001234);
        clr_req[0]  = 1'b1;
        rd_addr0[0] = 3'd7;
        cycle();
        idle_inputs();
        rd_addr0[0] = 3'd7;
        hits = 0; k = 0;
        while (clr_busy[0] && k < 20) begin
            k++;
            cycle();
            if (rd_data0[0] === 32'h00001234) hits++;
        end
        check("simul clear cycles", k, 8);
        check("simul reads of 0x1234", hits, 7);
        check("simul last clear read", rd_data0[0], 32'h0);
        cycle();
        check("simul after clear", rd_data0[0], 32'h0);

        // ---- randomized traffic on both instances ----
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                drive_wr(d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)), $urandom);
                rd_addr0[d] = AW'($urandom_range(0, 7));
                rd_addr1[d] = AW'($urandom_range(0, 7));
                clr_req[d]  = ($urandom_range(0, 39) == 0);
            end
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
